// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler
//   Owns the single DDR command bus. Arbitrates refresh > mode-register write
//   > read/write request, tracks open banks/rows and spaces commands with a
//   shared gap counter plus per-bank tRAS counters. Outputs are registered, so
//   a command chosen at a rising edge is on the bus for the following cycle.
// Ports:
//   clock_t_i, reset_i            clock, synchronous active-high reset
//   req_*_i / req_ready_o         read/write request handshake
//   ref_req_i / ref_ack_o         refresh request level / ack pulse with REF
//   mrs_req_i, mrs_data_i         mode-register request level and payload
//   mrs_ack_o                     ack pulse with MRS
//   cmd_valid_o, cmd_type_o,
//   cmd_bank_o, cmd_addr_o        command bus towards the C/A driver
//   idle_o                        scheduler is in S_IDLE
module ddr_cmd_scheduler #(
   parameter int NUM_BANK = 4,
   parameter int ROW_W    = 15,
   parameter int COL_W    = 10,
   parameter int MRS_W    = 18,
   parameter int T_RCD    = 11,
   parameter int T_RP     = 11,
   parameter int T_RAS    = 28,
   parameter int T_CCD    = 4,
   parameter int T_RFC    = 160,
   parameter int T_MOD    = 24,
   localparam int BA_W    = $clog2(NUM_BANK)
) (
   input  logic             clock_t_i,
   input  logic             reset_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_write_i,
   input  logic [BA_W-1:0]  req_bank_i,
   input  logic [ROW_W-1:0] req_row_i,
   input  logic [COL_W-1:0] req_col_i,
   input  logic             ref_req_i,
   output logic             ref_ack_o,
   input  logic             mrs_req_i,
   input  logic [MRS_W-1:0] mrs_data_i,
   output logic             mrs_ack_o,
   output logic             cmd_valid_o,
   output logic [2:0]       cmd_type_o,
   output logic [BA_W-1:0]  cmd_bank_o,
   output logic [MRS_W-1:0] cmd_addr_o,
   output logic             idle_o
);
   localparam logic [2:0] CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD  = 3'd2, CMD_WR  = 3'd3,
                          CMD_PRE = 3'd4, CMD_PREA = 3'd5, CMD_REF = 3'd6, CMD_MRS = 3'd7;

   localparam int M0    = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int M1    = (M0 > T_CCD) ? M0 : T_CCD;
   localparam int M2    = (M1 > T_RFC) ? M1 : T_RFC;
   localparam int T_MAX = (M2 > T_MOD) ? M2 : T_MOD;
   localparam int GAP_W = $clog2(T_MAX + 1);
   localparam int RAS_W = $clog2(T_RAS + 1);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_RW, S_PREA, S_REF, S_MRS} state_t;

   state_t                             state_q, state_d;
   logic [GAP_W-1:0]                   gap_q;
   logic [NUM_BANK-1:0][RAS_W-1:0]     ras_q;
   logic [NUM_BANK-1:0]                open_q;
   logic [NUM_BANK-1:0][ROW_W-1:0]     row_q;
   logic                               wr_q, pend_mrs_q;
   logic [BA_W-1:0]                    bank_q;
   logic [ROW_W-1:0]                   lrow_q;
   logic [COL_W-1:0]                   col_q;

   logic [2:0]       cmd_type_d;
   logic [BA_W-1:0]  cmd_bank_d;
   logic [MRS_W-1:0] cmd_addr_d;
   logic [GAP_W-1:0] gap_ld;
   logic             ref_ack_d, mrs_ack_d;
   logic             gap_zero, ras_all_zero, any_open, issue, accept, row_hit;

   assign gap_zero = (gap_q == '0);
   assign any_open = |open_q;
   assign issue    = (cmd_type_d != CMD_NOP);

   always_comb begin
      ras_all_zero = 1'b1;
      for (int b = 0; b < NUM_BANK; b++)
         if (ras_q[b] != '0) ras_all_zero = 1'b0;
   end

   assign req_ready_o = !reset_i && (state_q == S_IDLE) && !ref_req_i && !mrs_req_i;
   assign accept      = req_valid_i && req_ready_o;
   assign row_hit     = open_q[req_bank_i] && (row_q[req_bank_i] == req_row_i);
   assign idle_o      = (state_q == S_IDLE);

   // state register
   always_ff @(posedge clock_t_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // next state; every non-idle state advances exactly when its command issues
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ref_req_i || mrs_req_i)
               state_d = any_open ? S_PREA : (ref_req_i ? S_REF : S_MRS);
            else if (req_valid_i)
               state_d = row_hit ? S_RW : (open_q[req_bank_i] ? S_PRE : S_ACT);
         end
         S_PRE:   if (issue) state_d = S_ACT;
         S_ACT:   if (issue) state_d = S_RW;
         S_PREA:  if (issue) state_d = pend_mrs_q ? S_MRS : S_REF;
         default: if (issue) state_d = S_IDLE;
      endcase
   end

   // command selection for this edge
   always_comb begin
      cmd_type_d = CMD_NOP;
      cmd_bank_d = '0;
      cmd_addr_d = '0;
      gap_ld     = '0;
      ref_ack_d  = 1'b0;
      mrs_ack_d  = 1'b0;
      if (gap_zero) begin
         case (state_q)
            S_PRE: if (ras_q[bank_q] == '0) begin
               cmd_type_d = CMD_PRE;
               cmd_bank_d = bank_q;
               gap_ld     = GAP_W'(T_RP - 1);
            end
            S_ACT: begin
               cmd_type_d = CMD_ACT;
               cmd_bank_d = bank_q;
               cmd_addr_d = MRS_W'(lrow_q);
               gap_ld     = GAP_W'(T_RCD - 1);
            end
            S_RW: begin
               cmd_type_d = wr_q ? CMD_WR : CMD_RD;
               cmd_bank_d = bank_q;
               cmd_addr_d = MRS_W'(col_q);
               gap_ld     = GAP_W'(T_CCD - 1);
            end
            S_PREA: if (ras_all_zero) begin
               cmd_type_d = CMD_PREA;
               gap_ld     = GAP_W'(T_RP - 1);
            end
            S_REF: begin
               cmd_type_d = CMD_REF;
               ref_ack_d  = 1'b1;
               gap_ld     = GAP_W'(T_RFC - 1);
            end
            S_MRS: begin
               cmd_type_d = CMD_MRS;
               cmd_addr_d = mrs_data_i;
               mrs_ack_d  = 1'b1;
               gap_ld     = GAP_W'(T_MOD - 1);
            end
            default: ;
         endcase
      end
   end

   // bank bookkeeping, counters and registered command bus
   always_ff @(posedge clock_t_i) begin
      if (reset_i) begin
         gap_q       <= '0;
         ras_q       <= '0;
         open_q      <= '0;
         row_q       <= '0;
         wr_q        <= 1'b0;
         pend_mrs_q  <= 1'b0;
         bank_q      <= '0;
         lrow_q      <= '0;
         col_q       <= '0;
         cmd_valid_o <= 1'b0;
         cmd_type_o  <= CMD_NOP;
         cmd_bank_o  <= '0;
         cmd_addr_o  <= '0;
         ref_ack_o   <= 1'b0;
         mrs_ack_o   <= 1'b0;
      end else begin
         gap_q <= issue ? gap_ld : (gap_zero ? '0 : gap_q - 1'b1);
         for (int b = 0; b < NUM_BANK; b++) begin
            if (cmd_type_d == CMD_ACT && bank_q == BA_W'(b)) ras_q[b] <= RAS_W'(T_RAS - 1);
            else if (ras_q[b] != '0)                          ras_q[b] <= ras_q[b] - 1'b1;
         end
         case (cmd_type_d)
            CMD_ACT: begin
               open_q[bank_q] <= 1'b1;
               row_q[bank_q]  <= lrow_q;
            end
            CMD_PRE:  open_q[bank_q] <= 1'b0;
            CMD_PREA: open_q         <= '0;
            default: ;
         endcase
         if (accept) begin
            wr_q   <= req_write_i;
            bank_q <= req_bank_i;
            lrow_q <= req_row_i;
            col_q  <= req_col_i;
         end
         // remembers where the shared PREA detour ends
         if (state_q == S_IDLE && (ref_req_i || mrs_req_i)) pend_mrs_q <= !ref_req_i;
         cmd_valid_o <= issue;
         cmd_type_o  <= cmd_type_d;
         cmd_bank_o  <= cmd_bank_d;
         cmd_addr_o  <= cmd_addr_d;
         ref_ack_o   <= ref_ack_d;
         mrs_ack_o   <= mrs_ack_d;
      end
   end
endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler. A transaction-level model turns each
// accepted operation into a list of (cycle, command) entries using earliest-time
// arithmetic over the timing rules; a per-cycle monitor compares the bus and
// handshakes against it, and each scenario pins the model with literal offsets.
module tb_ddr_cmd_scheduler;
   localparam int NB = 4, ROW_W = 15, COL_W = 10, MRS_W = 18;
   localparam int T_RCD = 11, T_RP = 11, T_RAS = 28, T_CCD = 4, T_RFC = 160, T_MOD = 24;
   localparam int NOP = 0, ACT = 1, RD = 2, WR = 3, PRE = 4, PREA = 5, REF = 6, MRS = 7;
   localparam logic [MRS_W-1:0] MRS_VAL = 18'h2A5C3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0, req_write = 1'b0;
   logic [1:0]       req_bank = '0;
   logic [ROW_W-1:0] req_row = '0;
   logic [COL_W-1:0] req_col = '0;
   logic             ref_req = 1'b0, mrs_req = 1'b0;
   logic [MRS_W-1:0] mrs_data = MRS_VAL;
   logic             req_ready, ref_ack, mrs_ack, cmd_valid, idle;
   logic [2:0]       cmd_type;
   logic [1:0]       cmd_bank;
   logic [MRS_W-1:0] cmd_addr;

   always #5 clk = ~clk;

   ddr_cmd_scheduler dut (
      .clock_t_i(clk), .reset_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_bank_i(req_bank), .req_row_i(req_row), .req_col_i(req_col),
      .ref_req_i(ref_req), .ref_ack_o(ref_ack),
      .mrs_req_i(mrs_req), .mrs_data_i(mrs_data), .mrs_ack_o(mrs_ack),
      .cmd_valid_o(cmd_valid), .cmd_type_o(cmd_type), .cmd_bank_o(cmd_bank),
      .cmd_addr_o(cmd_addr), .idle_o(idle));

   typedef struct {int cyc; int typ; int bank; int addr;} ecmd_t;
   ecmd_t exp_q[$];

   int pass_cnt = 0, tot_cnt = 0;
   int cyc = 0;
   bit m_open[NB];
   int m_row[NB];
   int m_act[NB];
   int m_lc = -1000, m_tl = 0, m_busy = 0;
   int acc_cnt = 0, acc_cyc = 0, ref_cnt = 0, mrs_cnt = 0, ref_dec = 0;
   int seen_cyc[8] = '{default: -1};
   int seen_addr[8] = '{default: -1};

   task automatic chk(string nm, int got, int expv);
      tot_cnt++;
      if (got == expv) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, expv, cyc);
   endtask

   function automatic int imax(int a, int b);
      return (a > b) ? a : b;
   endfunction

   function automatic void push(int c, int t, int b, int a);
      ecmd_t e;
      e.cyc = c; e.typ = t; e.bank = b; e.addr = a;
      exp_q.push_back(e);
   endfunction

   function automatic void model_reset();
      for (int b = 0; b < NB; b++) begin m_open[b] = 0; m_row[b] = 0; m_act[b] = -1000; end
      m_lc = -1000; m_tl = 0; m_busy = cyc;
      exp_q.delete();
   endfunction

   // earliest-time schedule of one read/write decided at edge e
   function automatic void sched_req(int e, int w, int b, int r, int c);
      int t0, ta, tp, tr;
      t0 = imax(e + 1, m_lc + m_tl);
      if (m_open[b] && m_row[b] == r) tr = t0;
      else begin
         if (m_open[b]) begin
            tp = imax(t0, m_act[b] + T_RAS);
            push(tp, PRE, b, 0);
            ta = tp + T_RP;
         end else ta = t0;
         push(ta, ACT, b, r);
         m_open[b] = 1; m_row[b] = r; m_act[b] = ta;
         tr = ta + T_RCD;
      end
      push(tr, w ? WR : RD, b, c);
      m_lc = tr; m_tl = T_CCD; m_busy = tr;
   endfunction

   function automatic void sched_maint(int e, bit is_ref);
      int t0, x, rmax;
      bit any;
      t0 = imax(e + 1, m_lc + m_tl);
      any = 0; rmax = -1000;
      for (int b = 0; b < NB; b++) begin
         any = any | m_open[b];
         rmax = imax(rmax, m_act[b] + T_RAS);
      end
      if (any) begin
         x = imax(t0, rmax);
         push(x, PREA, 0, 0);
         for (int b = 0; b < NB; b++) m_open[b] = 0;
         x = x + T_RP;
      end else x = t0;
      push(x, is_ref ? REF : MRS, 0, is_ref ? 0 : int'(mrs_data));
      m_lc = x; m_tl = is_ref ? T_RFC : T_MOD; m_busy = x;
   endfunction

   // model step at each edge, then compare the outputs of the following cycle
   always @(posedge clk) begin
      ecmd_t f;
      int et, eb, ea;
      logic [23:0] dv, ev;
      logic [3:0]  dh, eh;
      cyc++;
      if (rst) model_reset();
      else if (cyc > m_busy) begin
         if (ref_req) begin sched_maint(cyc, 1); ref_dec = cyc; end
         else if (mrs_req) sched_maint(cyc, 0);
         else if (req_valid) begin
            sched_req(cyc, int'(req_write), int'(req_bank), int'(req_row), int'(req_col));
            acc_cyc = cyc; acc_cnt++;
         end
      end
      #1;
      et = NOP; eb = 0; ea = 0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         f = exp_q.pop_front();
         et = f.typ; eb = f.bank; ea = f.addr;
      end
      ev = {1'(et != NOP), 3'(et), 2'(eb), 18'(ea)};
      dv = {cmd_valid, cmd_type, cmd_bank, cmd_addr};
      chk("cmd_bus", int'(dv), int'(ev));
      eh = {1'(et == REF), 1'(et == MRS), 1'(cyc >= m_busy),
            1'(!rst && cyc >= m_busy && !ref_req && !mrs_req)};
      dh = {ref_ack, mrs_ack, idle, req_ready};
      chk("ack_idle_ready", int'(dh), int'(eh));
      if (cmd_valid) begin seen_cyc[cmd_type] = cyc; seen_addr[cmd_type] = int'(cmd_addr); end
      if (et == REF) ref_cnt++;
      if (et == MRS) mrs_cnt++;
   end

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 600; i++) begin
         if (exp_q.size() == 0 && cyc >= m_busy) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   task automatic raise_req(input int w, input int b, input int r, input int c);
      int snap = acc_cnt;
      req_valid = 1'b1; req_write = 1'(w); req_bank = 2'(b);
      req_row = ROW_W'(r); req_col = COL_W'(c);
      for (int i = 0; i < 400 && acc_cnt == snap; i++) @(negedge clk);
      if (acc_cnt == snap) chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
   endtask

   task automatic do_req(input int w, input int b, input int r, input int c);
      raise_req(w, b, r, c);
      wait_idle();
   endtask

   initial begin
      int act0, rd0, base, t, a, rs, rc, mc;
      #500000;
      $display("FAIL watchdog: simulation ran too long");
      $fatal(1);
   end

   initial begin
      int act0, rd0, base, t, rs, rc, mc;
      bit ok;
      repeat (3) @(negedge clk);
      chk("reset_idle", int'(idle), 1);
      chk("reset_cmd_valid", int'(cmd_valid), 0);
      chk("reset_ready", int'(req_ready), 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // closed bank read
      do_req(0, 0, 5, 8);
      chk("closed_act_cyc", seen_cyc[ACT], acc_cyc + 1);
      chk("closed_act_row", seen_addr[ACT], 5);
      chk("closed_rd_cyc", seen_cyc[RD], acc_cyc + 12);
      chk("closed_rd_col", seen_addr[RD], 8);
      act0 = seen_cyc[ACT]; rd0 = seen_cyc[RD];

      // row hit write right behind the read: tCCD spacing
      base = cyc;
      do_req(1, 0, 5, 16);
      chk("hit_accept_cyc", acc_cyc, rd0 + 1);
      chk("hit_wr_cyc", seen_cyc[WR], rd0 + 4);
      chk("hit_wr_col", seen_addr[WR], 16);
      chk("hit_no_act", int'(seen_cyc[ACT] < base), 1);

      // row miss on bank 0: PRE gated by tRAS of the first ACT
      do_req(0, 0, 9, 2);
      chk("miss_pre_cyc", seen_cyc[PRE], act0 + 28);
      chk("miss_act_cyc", seen_cyc[ACT], act0 + 39);
      chk("miss_act_row", seen_addr[ACT], 9);
      chk("miss_rd_cyc", seen_cyc[RD], act0 + 50);

      // open bank 1 then refresh
      do_req(0, 1, 3, 1);
      t = seen_cyc[ACT];
      rc = ref_cnt;
      ref_req = 1'b1;
      for (int i = 0; i < 400 && ref_cnt == rc; i++) @(negedge clk);
      if (ref_cnt == rc) chk("ref_timeout", 0, 1);
      ref_req = 1'b0;
      wait_idle();
      chk("ref_prea_cyc", seen_cyc[PREA], t + 28);
      chk("ref_ref_cyc", seen_cyc[REF], t + 39);
      do_req(0, 3, 0, 0);
      chk("after_ref_act_cyc", seen_cyc[ACT], t + 199);

      // all three requesters at once on an idle, all-closed device
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rc = ref_cnt; mc = mrs_cnt; rs = acc_cnt;
      ref_req = 1'b1; mrs_req = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_bank = 2'd2; req_row = 15'd7; req_col = 10'd3;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (ref_cnt != rc) ref_req = 1'b0;
         if (mrs_cnt != mc) mrs_req = 1'b0;
         if (acc_cnt != rs) req_valid = 1'b0;
         if (!ref_req && !mrs_req && !req_valid) begin ok = 1; break; end
      end
      if (!ok) chk("arb_timeout", 0, 1);
      wait_idle();
      chk("arb_ref_cyc", seen_cyc[REF], ref_dec + 1);
      chk("arb_mrs_cyc", seen_cyc[MRS], ref_dec + 161);
      chk("arb_mrs_addr", seen_addr[MRS], int'(MRS_VAL));
      chk("arb_req_accept", acc_cyc, ref_dec + 162);
      chk("arb_act_cyc", seen_cyc[ACT], ref_dec + 185);

      // reset while waiting in S_PRE
      do_req(0, 2, 1, 3);
      base = cyc;
      raise_req(0, 2, 4, 5);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_idle", int'(idle), 1);
      chk("midrst_cmd_valid", int'(cmd_valid), 0);
      rst = 1'b0;
      wait_idle();
      base = cyc;
      do_req(0, 2, 4, 5);
      chk("postrst_no_pre", int'(seen_cyc[PRE] < base), 1);
      chk("postrst_act_cyc", seen_cyc[ACT], acc_cyc + 1);
      chk("postrst_rd_cyc", seen_cyc[RD], acc_cyc + 12);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule

// File: doc/ddr_cmd_scheduler.md
# ddr_cmd_scheduler

Sequences all DRAM commands onto the single DDR command bus. It shares that bus between three requesters: the read/write request port, the controller's refresh request, and the controller's mode-register update request. It tracks open banks and rows, enforces tRCD/tRP/tRAS/tCCD/tRFC/tMOD spacing, and emits one command per cycle at most. It sits between the top-level controller FSM and the command/address driver.

## Interface
- NUM_BANK, 4: number of banks; BA_W = $clog2(NUM_BANK).
- ROW_W, 15: row address width.
- COL_W, 10: column address width.
- MRS_W, 18: mode-register payload width. Requires MRS_W >= ROW_W >= COL_W.
- T_RCD, 11: minimum cycles from ACT to RD/WR.
- T_RP, 11: minimum cycles from PRE/PREA to ACT/REF/MRS.
- T_RAS, 28: minimum cycles from ACT to PRE of the same bank.
- T_CCD, 4: minimum cycles from RD/WR to the next RD/WR.
- T_RFC, 160: minimum cycles from REF to any command.
- T_MOD, 24: minimum cycles from MRS to any command.
- All timing parameters are ≥ 1.

Ports:
- clock_t, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- req_valid, in, 1: read/write request present.
- req_ready, out, 1: request accepted when req_valid & req_ready are both high at a clock edge.
- req_write, in, 1: 1 = write, 0 = read.
- req_bank, in, BA_W: target bank.
- req_row, in, ROW_W: target row.
- req_col, in, COL_W: target column.
- ref_req, in, 1: refresh request, level; held until ref_ack.
- ref_ack, out, 1: one-cycle pulse, coincident with the REF command.
- mrs_req, in, 1: mode-register write request, level; held until mrs_ack.
- mrs_data, in, MRS_W: MRS payload; stable while mrs_req is high.
- mrs_ack, out, 1: one-cycle pulse, coincident with the MRS command.
- cmd_valid, out, 1: a command is on the bus this cycle.
- cmd_type, out, 3: NOP=0, ACT=1, RD=2, WR=3, PRE=4, PREA=5, REF=6, MRS=7.
- cmd_bank, out, BA_W: command bank; 0 for PREA, REF and MRS.
- cmd_addr, out, MRS_W: ACT carries the row, RD/WR carry the column, MRS carries mrs_data, all zero-extended; 0 otherwise.
- idle, out, 1: high while in S_IDLE.

## Operation
- State machine states: S_IDLE, S_PRE, S_ACT, S_RW, S_PREA, S_REF, S_MRS.
- S_IDLE arbitration uses fixed priority: ref_req > mrs_req > req_valid.
  - req_ready = S_IDLE & !ref_req & !mrs_req.
  - On request accept, latch write/bank/row/col.
  - Row hit (bank open, same row) -> S_RW.
  - Bank closed -> S_ACT.
  - Bank open with a different row -> S_PRE.
- S_PRE: issue PRE to the latched bank when gap==0 and ras[bank]==0. Mark the bank closed, then go to S_ACT.
- S_ACT: issue ACT when gap==0. Set open[bank]=1 and row[bank]=latched row, load ras[bank]=T_RAS-1, then go to S_RW.
- S_RW: issue RD or WR when gap==0, then return to S_IDLE.
- Refresh path:
  - If any bank is open -> S_PREA. PREA issues when gap==0 and every ras==0, clears all open flags, then goes to S_REF.
  - If no bank is open -> S_REF directly.
  - S_REF issues REF with ref_ack when gap==0, then returns to S_IDLE.
- MRS path: identical to the refresh path, ending in S_MRS, which issues MRS with mrs_ack.
- Gap counter: loaded on each command with (T−1) of that command's timing, using T_RCD/T_RP/T_CCD/T_RFC/T_MOD. Decrements to 0 and saturates at 0.
- Per-bank ras counters decrement independently and saturate at 0.
- A command issued at cycle c with spacing T allows the next dependent command at cycle c+T at the earliest.
- Reset values: cmd_valid=0, cmd_type=NOP, cmd_bank=0, cmd_addr=0, req_ready=0, ref_ack=0, mrs_ack=0, idle=1. All banks closed, all counters 0, state S_IDLE.

## Timing
- Request accepted at edge N, row hit, gap==0: RD/WR has cmd_valid at cycle N+1.
- Closed bank: ACT at N+1, RD/WR at N+1+T_RCD.
- Row miss: PRE at max(N+1, ACT_prev+T_RAS), ACT at PRE+T_RP, RD/WR at ACT+T_RCD.
- At most one command per cycle; cmd_valid=0 in every wait cycle.
- ref_req, mrs_req and req_valid asserted in the same S_IDLE cycle: refresh is serviced first and req_ready stays 0.
- A request arriving while the FSM is busy waits. req_ready never rises outside S_IDLE.
- Reset asserted mid-sequence takes effect on the next edge. The pending operation is dropped and no ack is issued.

## Test plan
- Read to closed bank 0 (row 5, col 8), accepted at cycle 10 -> ACT bank0 addr 5 at cycle 11; RD bank0 addr 8 at cycle 22.
- After that RD, a write to bank 0 row 5 col 16 accepted at cycle 23 -> WR at cycle 26 (tCCD gap).
- Bank 0 open on row 5 (ACT at 11), read to row 9 accepted at cycle 23 -> PRE at 39, ACT row 9 at 50, RD at 61.
- ref_req with bank 1 opened at cycle T -> PREA at T+28, REF with ref_ack at T+39, next command no earlier than T+199.
- ref_req, mrs_req and req_valid all high on an idle, all-closed device at cycle 5 -> REF at 6, MRS (cmd_addr=mrs_data) at 166, request ACT at 190.
- Reset pulsed during an S_PRE wait -> next cycle: idle=1, cmd_valid=0, all banks closed; a new closed-bank read gets ACT one cycle after acceptance.
